scanwin_sequencer: RTL and testbench
====================================

SCANWIN_SEQUENCER -- requirements
Module: scanwin_sequencer

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 640, pixels per line (2..1023).
REQ-002 SHALL have parameter FRAME_HEIGHT, default 480, lines per frame (2..1023).
REQ-003 SHALL have parameter BLOCK_WIDTH, default 1, window columns (1..FRAME_WIDTH).
REQ-004 SHALL have parameter BLOCK_HEIGHT, default 8, window rows (1..FRAME_HEIGHT).
REQ-005 SHALL have ports, one clock, reset synchronous and active-high:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream pixel valid.
- in_sof  in  1  first pixel of frame; qualified by in_valid.
- in_ready  out  1  pixel accepted when in_valid&in_ready.
- win_enable  out  1  combinational; drives the window buffer enable; equals in_valid&in_ready.
- win_valid  out  1  window buffer holds a complete window.
- out_ready  in  1  downstream consumes the window when win_valid&out_ready.
- win_row  out  10  frame row of the window's bottom-right pixel.
- win_col  out  10  frame column of the window's bottom-right pixel.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- sof_err  out  1  sticky; set on protocol error.
- busy  out  1  high in any state except IDLE.

Function
REQ-006 SHALL implement states IDLE, FILL, RUN, DONE.
REQ-007 IDLE: in_ready=1; pixels without in_sof dropped (accepted, win_enable=0, counters held); accepted in_sof pixel -> col=1, row=0, win_enable=1; next state FILL, or RUN if BLOCK_HEIGHT==1.
REQ-008 Counters: col increments per accepted pixel; on wrap FRAME_WIDTH-1->0 row increments.
REQ-009 FILL -> RUN on acceptance of the pixel at (col=FRAME_WIDTH-1, row=BLOCK_HEIGHT-2).
REQ-010 RUN -> DONE on acceptance of the pixel at (FRAME_WIDTH-1, FRAME_HEIGHT-1).
REQ-011 DONE: lasts one cycle; frame_done=1; in_ready=0; -> IDLE.
REQ-012 Window-complete condition for an accepted pixel at (r,c): r>=BLOCK_HEIGHT-1 and c>=BLOCK_WIDTH-1.
REQ-013 win_valid SHALL rise the cycle after accepting a pixel meeting REQ-012, with win_row/win_col = that (r,c) registered at the same edge.
REQ-014 win_valid SHALL clear after the cycle in which win_valid&out_ready, unless a new complete-window pixel is accepted in that same cycle (stays 1, coordinates update).
REQ-015 Backpressure: in FILL/RUN, in_ready = !win_valid | out_ready; the buffer never advances over an unconsumed window.
REQ-016 Latency: pixel accepted at edge N -> win_valid visible after edge N+1, i.e. one cycle.
REQ-017 in_sof accepted in FILL/RUN: set sof_err; treat as a new frame start (col=1, row=0, FILL); clear win_valid.
REQ-018 Line end without in_sof is normal; there is no end-of-line input; geometry comes only from parameters.
REQ-019 sof_err SHALL clear only on rst.
REQ-020 busy=1 in FILL, RUN, DONE.
REQ-021 win_row/win_col hold their value while win_valid=0.

Reset
REQ-022 On rst=1 at a clock edge, the block SHALL enter IDLE with row=col=0, win_valid=0, win_row=win_col=0, frame_done=0, sof_err=0, busy=0.
REQ-023 While rst=1, in_ready=0 and win_enable=0.
REQ-024 rst asserted mid-frame SHALL abort the frame with no frame_done pulse; the next frame needs in_sof.

Verification
REQ-025 Params 8x4, BH=2, BW=2, out_ready=1, continuous frame -> first win_valid after pixel (1,1) accepted, with win_row=1, win_col=1; 7 valid windows on row 1, 7 on row 2, 7 on row 3; frame_done one cycle after pixel (3,7) is accepted.
REQ-026 Same params, out_ready=0 after the first window -> in_ready=0, win_enable=0, and the coordinates stay (1,1) until out_ready=1.
REQ-027 Pixels with in_valid and no in_sof in IDLE -> win_enable=0 and busy=0 throughout.
REQ-028 in_sof at row 2 col 3 mid-frame -> sof_err=1 persists, row/col restart at 0/1, win_valid=0 next cycle.
REQ-029 rst pulse at row 2 -> all outputs return to reset values next cycle; no frame_done pulse.
REQ-030 Defaults 640x480 BH=8 BW=1, random in_valid/out_ready -> exactly 640*473 windows, monotonically raster-ordered, one frame_done.

Source files
------------

// File: rtl/scanwin_sequencer.sv
// Raster scan sequencer for a sliding-window buffer: tracks the pixel position within a frame,
// enables buffer writes, and reports when the buffer holds a complete window.
module scanwin_sequencer #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int BLOCK_WIDTH  = 1,
    parameter int BLOCK_HEIGHT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_sof,
    output logic       in_ready,
    output logic       win_enable,
    output logic       win_valid,
    input  logic       out_ready,
    output logic [9:0] win_row,
    output logic [9:0] win_col,
    output logic       frame_done,
    output logic       sof_err,
    output logic       busy
);
    // Handshakes: a pixel transfers on a rising edge where in_valid & in_ready are both high;
    // a window transfers on a rising edge where win_valid & out_ready are both high.

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    localparam logic [9:0] LAST_COL = 10'(FRAME_WIDTH - 1);
    localparam logic [9:0] LAST_ROW = 10'(FRAME_HEIGHT - 1);
    localparam logic [9:0] FILL_ROW = 10'((BLOCK_HEIGHT > 1) ? BLOCK_HEIGHT - 2 : 0);
    localparam logic [9:0] WIN_ROW0 = 10'(BLOCK_HEIGHT - 1);
    localparam logic [9:0] WIN_COL0 = 10'(BLOCK_WIDTH - 1);
    localparam state_t     START_ST = (BLOCK_HEIGHT == 1) ? RUN : FILL;

    state_t     state;
    logic [9:0] row;
    logic [9:0] col;
    logic       in_frame;
    logic       accept;
    logic [9:0] cur_row;
    logic [9:0] cur_col;
    logic       complete;

    assign in_frame   = (state == FILL) || (state == RUN);
    assign in_ready   = !rst && ((state == IDLE) || (in_frame && (!win_valid || out_ready)));
    assign accept     = in_valid && in_ready;
    // IDLE accepts stray pixels only to discard them; they never reach the buffer.
    assign win_enable = accept && (in_frame || in_sof);
    assign cur_row    = in_sof ? 10'd0 : row;
    assign cur_col    = in_sof ? 10'd0 : col;
    assign complete   = (cur_row >= WIN_ROW0) && (cur_col >= WIN_COL0);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row        <= 10'd0;
            col        <= 10'd0;
            win_valid  <= 1'b0;
            win_row    <= 10'd0;
            win_col    <= 10'd0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (win_valid && out_ready) begin
                win_valid <= 1'b0;
            end
            if (win_enable) begin
                if (in_sof && in_frame) begin
                    sof_err   <= 1'b1;
                    win_valid <= 1'b0;
                end else if (complete) begin
                    win_valid <= 1'b1;
                    win_row   <= cur_row;
                    win_col   <= cur_col;
                end
            end
            case (state)
                IDLE: begin
                    if (accept && in_sof) begin
                        row   <= 10'd0;
                        col   <= 10'd1;
                        state <= START_ST;
                    end
                end
                FILL, RUN: begin
                    if (accept && in_sof) begin
                        row   <= 10'd0;
                        col   <= 10'd1;
                        state <= START_ST;
                    end else if (accept) begin
                        if (col == LAST_COL) begin
                            col <= 10'd0;
                            row <= row + 10'd1;
                        end else begin
                            col <= col + 10'd1;
                        end
                        if (state == FILL && col == LAST_COL && row == FILL_ROW) begin
                            state <= RUN;
                        end
                        if (state == RUN && col == LAST_COL && row == LAST_ROW) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                            row        <= 10'd0;
                            col        <= 10'd0;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scanwin_sequencer.sv
// Bench for scanwin_sequencer: directed scenarios on an 8x4 frame with a 2x2 window, and a
// randomized multi-frame run on a 10x6 frame with a 4-wide, 3-tall window against a raster model.
module tb_scanwin_sequencer;
    localparam int B_FW = 10;
    localparam int B_FH = 6;
    localparam int B_BW = 4;
    localparam int B_BH = 3;
    localparam int B_NF = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_in_valid, a_in_sof, a_out_ready;
    logic       a_in_ready, a_win_enable, a_win_valid, a_frame_done, a_sof_err, a_busy;
    logic [9:0] a_win_row, a_win_col;
    logic       b_in_valid, b_in_sof, b_out_ready;
    logic       b_in_ready, b_win_enable, b_win_valid, b_frame_done, b_sof_err, b_busy;
    logic [9:0] b_win_row, b_win_col;

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];

    scanwin_sequencer #(.FRAME_WIDTH(8), .FRAME_HEIGHT(4), .BLOCK_WIDTH(2), .BLOCK_HEIGHT(2)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_sof(a_in_sof), .in_ready(a_in_ready),
        .win_enable(a_win_enable), .win_valid(a_win_valid), .out_ready(a_out_ready),
        .win_row(a_win_row), .win_col(a_win_col), .frame_done(a_frame_done),
        .sof_err(a_sof_err), .busy(a_busy)
    );

    scanwin_sequencer #(.FRAME_WIDTH(B_FW), .FRAME_HEIGHT(B_FH), .BLOCK_WIDTH(B_BW), .BLOCK_HEIGHT(B_BH)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_sof(b_in_sof), .in_ready(b_in_ready),
        .win_enable(b_win_enable), .win_valid(b_win_valid), .out_ready(b_out_ready),
        .win_row(b_win_row), .win_col(b_win_col), .frame_done(b_frame_done),
        .sof_err(b_sof_err), .busy(b_busy)
    );

    // Drive one pixel into instance a and return just after the edge that samples it.
    task automatic a_pixel(input bit sof, input bit ordy);
        @(negedge clk);
        a_in_valid  = 1'b1;
        a_in_sof    = sof;
        a_out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_in_valid = 1'b1; a_in_sof = 1'b1; a_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_sof = 1'b1; b_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0d want 0", a_in_ready); end
        checks++; if (a_win_enable !== 1'b0) begin errors++; $display("FAIL reset_win_enable got %0d want 0", a_win_enable); end
        checks++; if (a_win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid got %0d want 0", a_win_valid); end
        checks++; if (a_win_row !== 10'd0 || a_win_col !== 10'd0) begin errors++; $display("FAIL reset_coords got %0d,%0d want 0,0", a_win_row, a_win_col); end
        checks++; if (a_frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0d want 0", a_frame_done); end
        checks++; if (a_sof_err !== 1'b0) begin errors++; $display("FAIL reset_sof_err got %0d want 0", a_sof_err); end
        checks++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d/%0d want 0", a_busy, b_busy); end
        checks++; if (b_in_ready !== 1'b0 || b_win_enable !== 1'b0) begin errors++; $display("FAIL reset_b_ready got %0d/%0d want 0", b_in_ready, b_win_enable); end
        @(negedge clk);
        rst = 1'b0;
        a_in_valid = 1'b0; a_in_sof = 1'b0;
        b_in_valid = 1'b0; b_in_sof = 1'b0;
    endtask

    task automatic test_idle_drop;
        repeat (4) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_sof = 1'b0; a_out_ready = 1'b1;
            #1;
            checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %0d want 1", a_in_ready); end
            checks++; if (a_win_enable !== 1'b0) begin errors++; $display("FAIL idle_win_enable got %0d want 0", a_win_enable); end
            @(posedge clk);
            #1;
            checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0d want 0", a_busy); end
        end
    endtask

    task automatic test_frame;
        int  nrow[4];
        bit  expv;
        for (int i = 0; i < 4; i++) nrow[i] = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_sof = (k == 0); a_out_ready = 1'b1;
            #1;
            checks++; if (a_win_enable !== 1'b1) begin errors++; $display("FAIL frame_win_enable k=%0d got %0d want 1", k, a_win_enable); end
            @(posedge clk);
            #1;
            expv = (k / 8 >= 1) && (k % 8 >= 1);
            checks++; if (a_win_valid !== expv) begin errors++; $display("FAIL frame_win_valid k=%0d got %0d want %0d", k, a_win_valid, expv); end
            if (expv) begin
                checks++;
                if (a_win_row !== 10'(k / 8) || a_win_col !== 10'(k % 8)) begin
                    errors++; $display("FAIL frame_coords k=%0d got %0d,%0d want %0d,%0d", k, a_win_row, a_win_col, k / 8, k % 8);
                end
            end
            if (a_win_valid === 1'b1 && a_win_row < 10'd4) nrow[a_win_row]++;
            checks++; if (a_frame_done !== (k == 31)) begin errors++; $display("FAIL frame_done k=%0d got %0d want %0d", k, a_frame_done, k == 31); end
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        checks++; if (a_in_ready !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL done_state got ready=%0d busy=%0d want 0,1", a_in_ready, a_busy); end
        @(posedge clk);
        #1;
        checks++; if (a_frame_done !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL after_done got fd=%0d busy=%0d want 0,0", a_frame_done, a_busy); end
        checks++; if (a_win_valid !== 1'b0) begin errors++; $display("FAIL after_done_valid got %0d want 0", a_win_valid); end
        checks++; if (nrow[0] != 0) begin errors++; $display("FAIL row0_windows got %0d want 0", nrow[0]); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (nrow[i] != 7) begin errors++; $display("FAIL row%0d_windows got %0d want 7", i, nrow[i]); end
        end
    endtask

    task automatic test_backpressure;
        for (int k = 0; k < 10; k++) a_pixel(k == 0, 1'b1);
        checks++; if (a_win_valid !== 1'b1 || a_win_row !== 10'd1 || a_win_col !== 10'd1) begin
            errors++; $display("FAIL bp_first got v=%0d %0d,%0d want 1 1,1", a_win_valid, a_win_row, a_win_col);
        end
        repeat (4) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_sof = 1'b0; a_out_ready = 1'b0;
            #1;
            checks++; if (a_in_ready !== 1'b0 || a_win_enable !== 1'b0) begin errors++; $display("FAIL bp_stall got rdy=%0d en=%0d want 0,0", a_in_ready, a_win_enable); end
            @(posedge clk);
            #1;
            checks++; if (a_win_valid !== 1'b1 || a_win_row !== 10'd1 || a_win_col !== 10'd1) begin
                errors++; $display("FAIL bp_hold got v=%0d %0d,%0d want 1 1,1", a_win_valid, a_win_row, a_win_col);
            end
        end
        a_pixel(1'b0, 1'b1);
        checks++; if (a_win_valid !== 1'b1 || a_win_row !== 10'd1 || a_win_col !== 10'd2) begin
            errors++; $display("FAIL bp_resume got v=%0d %0d,%0d want 1 1,2", a_win_valid, a_win_row, a_win_col);
        end
    endtask

    task automatic test_sof_err;
        for (int k = 11; k < 19; k++) a_pixel(1'b0, 1'b1);
        a_pixel(1'b1, 1'b1);
        checks++; if (a_sof_err !== 1'b1) begin errors++; $display("FAIL sof_err_set got %0d want 1", a_sof_err); end
        checks++; if (a_win_valid !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL sof_restart got v=%0d busy=%0d want 0,1", a_win_valid, a_busy); end
        for (int rel = 1; rel <= 9; rel++) begin
            a_pixel(1'b0, 1'b1);
            checks++; if (a_win_valid !== (rel == 9)) begin errors++; $display("FAIL sof_refill rel=%0d got %0d want %0d", rel, a_win_valid, rel == 9); end
            checks++; if (a_sof_err !== 1'b1) begin errors++; $display("FAIL sof_err_sticky rel=%0d got %0d want 1", rel, a_sof_err); end
        end
        checks++; if (a_win_row !== 10'd1 || a_win_col !== 10'd1) begin errors++; $display("FAIL sof_coords got %0d,%0d want 1,1", a_win_row, a_win_col); end
    endtask

    task automatic test_rst_mid;
        for (int rel = 10; rel < 18; rel++) a_pixel(1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1; a_in_valid = 1'b1; a_in_sof = 1'b0; a_out_ready = 1'b1;
        #1;
        checks++; if (a_in_ready !== 1'b0 || a_win_enable !== 1'b0) begin errors++; $display("FAIL rst_ready got %0d/%0d want 0,0", a_in_ready, a_win_enable); end
        @(posedge clk);
        #1;
        checks++; if (a_busy !== 1'b0 || a_win_valid !== 1'b0 || a_sof_err !== 1'b0 || a_frame_done !== 1'b0) begin
            errors++; $display("FAIL rst_outputs got busy=%0d v=%0d err=%0d fd=%0d want 0", a_busy, a_win_valid, a_sof_err, a_frame_done);
        end
        checks++; if (a_win_row !== 10'd0 || a_win_col !== 10'd0) begin errors++; $display("FAIL rst_coords got %0d,%0d want 0,0", a_win_row, a_win_col); end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_sof = 1'b0; a_out_ready = 1'b1;
            @(posedge clk);
            #1;
            checks++; if (a_frame_done !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL rst_abort got fd=%0d busy=%0d want 0,0", a_frame_done, a_busy); end
        end
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    // Model: phase 0 waits for a start-of-frame, phase 1 counts pixels in raster order,
    // phase 2 is the single end-of-frame cycle. Window coordinates come from the pixel index.
    task automatic test_random;
        int  phase, k, frames, ncons, ndone, cyc, r, c;
        bit  mv, exp_rdy, acc, real_pix, cons;
        logic [19:0] got, want;
        phase = 0; k = 0; frames = 0; ncons = 0; ndone = 0; cyc = 0; mv = 1'b0;
        exp_q.delete();
        while (!(frames == B_NF && phase == 0 && !mv) && cyc < 20000) begin
            @(negedge clk);
            if (frames == B_NF && phase == 0) begin
                b_in_valid = 1'b0; b_in_sof = 1'b0; b_out_ready = 1'b1;
            end else begin
                b_in_valid  = ($urandom_range(0, 3) != 0);
                b_in_sof    = (phase == 0) && ($urandom_range(0, 2) == 0);
                b_out_ready = 1'($urandom_range(0, 1));
            end
            #1;
            exp_rdy = (phase == 0) ? 1'b1 : (phase == 2) ? 1'b0 : (!mv || b_out_ready);
            checks++; if (b_in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got %0d want %0d", cyc, b_in_ready, exp_rdy); end
            checks++; if (b_busy !== (phase != 0)) begin errors++; $display("FAIL rnd_busy cyc=%0d got %0d want %0d", cyc, b_busy, phase != 0); end
            checks++; if (b_frame_done !== (phase == 2)) begin errors++; $display("FAIL rnd_frame_done cyc=%0d got %0d want %0d", cyc, b_frame_done, phase == 2); end
            checks++; if (b_win_valid !== mv) begin errors++; $display("FAIL rnd_win_valid cyc=%0d got %0d want %0d", cyc, b_win_valid, mv); end
            acc      = b_in_valid && exp_rdy;
            real_pix = acc && (phase == 1 || b_in_sof);
            checks++; if (b_win_enable !== real_pix) begin errors++; $display("FAIL rnd_win_enable cyc=%0d got %0d want %0d", cyc, b_win_enable, real_pix); end
            cons = mv && b_out_ready;
            if (cons) begin
                want = exp_q.pop_front();
                got  = {b_win_row, b_win_col};
                checks++; if (got !== want) begin errors++; $display("FAIL rnd_coords cyc=%0d got %0d,%0d want %0d,%0d", cyc, got[19:10], got[9:0], want[19:10], want[9:0]); end
                ncons++;
                mv = 1'b0;
            end
            if (b_frame_done === 1'b1) ndone++;
            if (real_pix) begin
                r = k / B_FW;
                c = k % B_FW;
                if (r >= B_BH - 1 && c >= B_BW - 1) begin
                    exp_q.push_back({10'(r), 10'(c)});
                    mv = 1'b1;
                end
                k++;
                if (k == B_FW * B_FH) begin
                    k = 0; frames++; phase = 2;
                end else begin
                    phase = 1;
                end
            end else if (phase == 2) begin
                phase = 0;
            end
            cyc++;
            @(posedge clk);
        end
        checks++; if (cyc >= 20000) begin errors++; $display("FAIL rnd_timeout got %0d cycles want <20000", cyc); end
        checks++; if (ncons != B_NF * (B_FH - B_BH + 1) * (B_FW - B_BW + 1)) begin
            errors++; $display("FAIL rnd_window_count got %0d want %0d", ncons, B_NF * (B_FH - B_BH + 1) * (B_FW - B_BW + 1));
        end
        checks++; if (ndone != B_NF) begin errors++; $display("FAIL rnd_done_count got %0d want %0d", ndone, B_NF); end
        checks++; if (b_sof_err !== 1'b0) begin errors++; $display("FAIL rnd_sof_err got %0d want 0", b_sof_err); end
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_sof = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_sof = 1'b0; b_out_ready = 1'b0;
        test_reset();
        test_idle_drop();
        test_frame();
        test_backpressure();
        test_sof_err();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
